// File: rtl/fd_pkg.sv
// Shared definitions for the flash-data LUT read path: default bus widths,
// the arbiter state encoding and a small width helper used by the clients.
package fd_pkg;

  // Flash address and data widths used by every client of the LUT port
  localparam int FD_AW = 24;
  localparam int FD_DW = 32;

  // Arbiter states; 2'b11 is unused and steers back to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } fd_state_e;

  // Width of an index/counter able to hold 0..n-1, never narrower than 1 bit
  function automatic int fd_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fd_read_arbiter_if.sv
// Bundle of the requester-side handshake and the flash LUT read port.
// The arbiter uses the slave view; the surrounding system (requesters plus
// flash) uses the master view.
interface fd_read_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = fd_pkg::FD_AW,
  parameter int DW   = fd_pkg::FD_DW
);

  // Requester side
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt_ready;
  logic [DW-1:0]      gnt_data;
  logic               gnt_err;

  // Flash side
  logic [AW-1:0]      fd_address;
  logic               fd_valid;
  logic               fd_ready;
  logic [DW-1:0]      fd;

  modport slave (
    input  req_valid, req_addr, fd_ready, fd,
    output gnt_ready, gnt_data, gnt_err, fd_address, fd_valid
  );

  modport master (
    output req_valid, req_addr, fd_ready, fd,
    input  gnt_ready, gnt_data, gnt_err, fd_address, fd_valid
  );

endinterface

// File: rtl/fd_rr_pick.sv
// Combinational round-robin picker. Starting one past the previous winner
// and wrapping, it returns the first requester with its request bit set.
// Kept separate so other shared flash clients can reuse it.
module fd_rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   last_gnt,
  output logic            any,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk the requesters in priority order and keep the first active one
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IW'((int'(last_gnt) + off) % NREQ);
      if (!any && req_valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fd_read_arbiter.sv
// Shares the single flash-data LUT read port between NREQ requesters.
// One read runs at a time, winners are picked round-robin, a one-entry
// last-address cache short-circuits repeated reads, and a timeout turns a
// stalled flash into an error response instead of a hung requester.
module fd_read_arbiter
  import fd_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int AW          = FD_AW,
  parameter int DW          = FD_DW,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CACHE_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  fd_read_arbiter_if.slave     bus,
  input  logic                 cache_clr,
  output logic                 busy
);

  localparam int IW = fd_idx_w(NREQ);
  localparam int CW = fd_idx_w(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  fd_state_e     state_q, state_d;

  logic [IW-1:0] idx_q;
  logic [IW-1:0] last_gnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic          cache_vld_q;
  logic [AW-1:0] cache_addr_q;
  logic [DW-1:0] cache_data_q;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic [AW-1:0] pick_addr;
  logic          hit;
  logic          timeout;

  fd_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_valid (bus.req_valid),
    .last_gnt  (last_gnt_q),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  // Select the address slice belonging to the current round-robin winner
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_addr = bus.req_addr[i*AW +: AW];
      end
    end
  end

  // A clear arriving with the lookup forces a miss so stale data never escapes
  assign hit = (CACHE_EN != 0) && cache_vld_q && !cache_clr &&
               (pick_addr == cache_addr_q);

  // Last allowed ISSUE cycle with the flash still silent
  assign timeout = !bus.fd_ready && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and all port outputs, decoded from the registered state
  always_comb begin
    state_d        = state_q;
    bus.gnt_ready  = '0;
    bus.gnt_data   = '0;
    bus.gnt_err    = 1'b0;
    bus.fd_valid   = 1'b0;
    bus.fd_address = '0;
    busy           = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (pick_any) begin
          state_d = hit ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        bus.fd_valid   = 1'b1;
        bus.fd_address = addr_q;
        if (bus.fd_ready || timeout) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.gnt_ready[idx_q] = 1'b1;
        bus.gnt_data         = data_q;
        bus.gnt_err          = err_q;
        state_d              = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction datapath: winner latch, flash capture, timeout counter, cache
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q        <= '0;
      last_gnt_q   <= IW'(NREQ - 1);
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_any) begin
            idx_q  <= pick_idx;
            addr_q <= pick_addr;
            if (hit) begin
              data_q <= cache_data_q;
              err_q  <= 1'b0;
            end
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.fd_ready) begin
            data_q <= bus.fd;
            err_q  <= 1'b0;
            if (CACHE_EN != 0) begin
              cache_addr_q <= addr_q;
              cache_data_q <= bus.fd;
              cache_vld_q  <= 1'b1;
            end
          end else if (timeout) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP: begin
          last_gnt_q <= idx_q;
          cnt_q      <= '0;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
      if (cache_clr) begin
        cache_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fd_read_arbiter.sv
// Self-checking bench for fd_read_arbiter: a behavioural flash responder,
// a grant scoreboard, a vector table of single-requester transactions and
// hand-written sequences for contention, reset mid-read and stray strobes.
module tb_fd_read_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 24;
  localparam int DW   = 32;
  localparam int TO   = 16;

  typedef struct {
    logic [1:0]  ready;
    logic [31:0] data;
    logic        err;
    logic [23:0] addr;
  } exp_t;

  typedef struct {
    logic [1:0]  req;
    logic [23:0] addr;
    logic [31:0] fdat;
    int          lat;
    bit          hang;
    int          clr;
    logic [1:0]  exp_ready;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_fdv;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic cache_clr;
  logic busy;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[10];
  vec_t extra;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   fdv_cnt = 0;
  int   gnt_count = 0;
  int   gnt_cyc = 0;
  bit   gnt_seen = 0;
  int   fl_lat = 0;
  bit   fl_hang = 0;
  logic [31:0] fl_data = '0;
  bit   stray = 0;
  int   fl_cnt = 0;
  int   base;
  int   waited;

  always #5 clk = ~clk;

  fd_read_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  fd_read_arbiter #(
    .NREQ        (NREQ),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT_CYC (TO),
    .CACHE_EN    (1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .cache_clr (cache_clr),
    .busy      (busy)
  );

  // Shared comparison helper
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc = cyc + 1;

  // Monitor/scoreboard first, then the flash responder for the coming edge
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.fd_valid) begin
        fdv_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_fd_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          checkOutput("fd_address", 32'(bus.fd_address), 32'(exp_q[0].addr));
        end
      end
      if (bus.gnt_ready != '0) begin
        gnt_count++;
        gnt_cyc  = cyc;
        gnt_seen = 1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_grant: got gnt_ready=0x%0h expected none (cycle %0d)", bus.gnt_ready, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("gnt_ready", 32'(bus.gnt_ready), 32'(mon_e.ready));
          checkOutput("gnt_data", bus.gnt_data, mon_e.data);
          checkOutput("gnt_err", 32'(bus.gnt_err), 32'(mon_e.err));
        end
      end
    end
    if (bus.fd_valid) begin
      bus.fd_ready = !fl_hang && (fl_cnt == fl_lat);
      bus.fd       = fl_data;
      fl_cnt++;
    end else begin
      fl_cnt       = 0;
      bus.fd_ready = stray;
      bus.fd       = stray ? 32'h1 : 32'h0;
    end
  end

  // Run one single-requester transaction and check latency and flash activity
  task automatic applyStimulus(input vec_t v, input string name);
    int start;
    int w;
    fl_lat   = v.lat;
    fl_hang  = v.hang;
    fl_data  = v.fdat;
    fdv_cnt  = 0;
    gnt_seen = 0;
    @(posedge clk);
    #1;
    bus.req_valid = v.req;
    bus.req_addr  = v.req[0] ? {24'h0, v.addr} : {v.addr, 24'h0};
    cache_clr     = (v.clr == 1);
    exp_q.push_back('{v.exp_ready, v.exp_data, v.exp_err, v.addr});
    start = cyc;
    @(posedge clk);
    #1;
    cache_clr = (v.clr == 2);
    w = 1;
    while (!gnt_seen && w < 200) begin
      @(posedge clk);
      #1;
      cache_clr = 1'b0;
      w++;
    end
    cache_clr     = 1'b0;
    bus.req_valid = '0;
    if (!gnt_seen) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_grant: got no grant after %0d cycles expected one", name, w);
      exp_q.delete();
    end else begin
      checkOutput({name, "_latency"}, 32'(gnt_cyc - start), 32'(v.exp_lat));
      checkOutput({name, "_fd_valid_cycles"}, 32'(fdv_cnt), 32'(v.exp_fdv));
    end
  endtask

  // Hold reset for two edges and check every output is cleared
  task automatic doReset();
    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    cache_clr     = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gnt_ready", 32'(bus.gnt_ready), 32'h0);
    checkOutput("reset_gnt_data", bus.gnt_data, 32'h0);
    checkOutput("reset_gnt_err", 32'(bus.gnt_err), 32'h0);
    checkOutput("reset_fd_valid", 32'(bus.fd_valid), 32'h0);
    checkOutput("reset_fd_address", 32'(bus.fd_address), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.fd_ready  = 1'b0;
    bus.fd        = '0;
    cache_clr     = 1'b0;

    //            req    addr        fdat          lat hang clr  ready  data          err fdv lat
    vecs[0] = '{2'b01, 24'h812345, 32'hDEADBEEF, 2, 1'b0, 0, 2'b01, 32'hDEADBEEF, 1'b0, 3, 4};
    vecs[1] = '{2'b01, 24'h812345, 32'h00000000, 0, 1'b0, 0, 2'b01, 32'hDEADBEEF, 1'b0, 0, 1};
    vecs[2] = '{2'b10, 24'h812345, 32'h00000000, 0, 1'b0, 0, 2'b10, 32'hDEADBEEF, 1'b0, 0, 1};
    vecs[3] = '{2'b01, 24'h812345, 32'h11111111, 0, 1'b0, 1, 2'b01, 32'h11111111, 1'b0, 1, 2};
    vecs[4] = '{2'b10, 24'h000010, 32'hFFFFFFFF, 0, 1'b1, 0, 2'b10, 32'h00000000, 1'b1, 16, 17};
    vecs[5] = '{2'b01, 24'h000010, 32'hCAFEF00D, 1, 1'b0, 0, 2'b01, 32'hCAFEF00D, 1'b0, 2, 3};
    vecs[6] = '{2'b10, 24'h000010, 32'h00000000, 0, 1'b0, 0, 2'b10, 32'hCAFEF00D, 1'b0, 0, 1};
    vecs[7] = '{2'b01, 24'h812345, 32'h12345678, 3, 1'b0, 0, 2'b01, 32'h12345678, 1'b0, 4, 5};
    vecs[8] = '{2'b01, 24'h000010, 32'h77777777, 0, 1'b0, 2, 2'b01, 32'h77777777, 1'b0, 1, 2};
    vecs[9] = '{2'b10, 24'h000010, 32'h88888888, 0, 1'b0, 0, 2'b10, 32'h88888888, 1'b0, 1, 2};

    doReset();

    // Contention straight out of reset: both hold requests, expect 0,1,0,1
    $display("[TB] contention sequence");
    fl_lat  = 1;
    fl_hang = 0;
    fl_data = 32'h0BADCAFE;
    base    = gnt_count;
    exp_q.push_back('{2'b01, 32'h0BADCAFE, 1'b0, 24'h000100});
    exp_q.push_back('{2'b10, 32'h0BADCAFE, 1'b0, 24'h000200});
    exp_q.push_back('{2'b01, 32'h0BADCAFE, 1'b0, 24'h000100});
    exp_q.push_back('{2'b10, 32'h0BADCAFE, 1'b0, 24'h000200});
    @(posedge clk);
    #1;
    bus.req_valid = 2'b11;
    bus.req_addr  = {24'h000200, 24'h000100};
    waited = 0;
    while (gnt_count - base < 4 && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    bus.req_valid = '0;
    checkOutput("contention_grants", 32'(gnt_count - base), 32'd4);
    checkOutput("contention_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Table of single transactions: miss, hits, clears, timeout
    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during ISSUE: read abandoned, no grant, cache invalidated
    $display("[TB] reset mid-read");
    fl_hang = 1;
    fl_data = 32'h0;
    fdv_cnt = 0;
    exp_q.push_back('{2'b01, 32'h0, 1'b0, 24'h000200});
    @(posedge clk);
    #1;
    bus.req_valid = 2'b01;
    bus.req_addr  = {24'h0, 24'h000200};
    waited = 0;
    while (fdv_cnt < 3 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("midread_fd_valid_before", 32'(bus.fd_valid), 32'h1);
    base          = gnt_count;
    rstn          = 1'b0;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    checkOutput("midread_fd_valid_after", 32'(bus.fd_valid), 32'h0);
    checkOutput("midread_busy_after", 32'(busy), 32'h0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midread_no_grant", 32'(gnt_count - base), 32'h0);
    fl_hang = 0;
    extra = '{2'b01, 24'h000010, 32'h55AA55AA, 0, 1'b0, 0, 2'b01, 32'h55AA55AA, 1'b0, 1, 2};
    applyStimulus(extra, "post_reset_miss");

    // Stray fd_ready while idle must neither grant nor touch the cache
    $display("[TB] stray fd_ready");
    base  = gnt_count;
    stray = 1;
    repeat (3) @(posedge clk);
    #1;
    stray = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stray_no_grant", 32'(gnt_count - base), 32'h0);
    checkOutput("stray_busy", 32'(busy), 32'h0);
    extra = '{2'b10, 24'h000010, 32'h00000000, 0, 1'b0, 0, 2'b10, 32'h55AA55AA, 1'b0, 0, 1};
    applyStimulus(extra, "stray_then_hit");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
